// File: rtl/frame_preemph.sv
// Pre-emphasis filter feeding a 256-entry ring, emitted as overlapping frames
// of FRAME_LEN words spaced HOP samples apart, with drop-on-overflow protection.
module frame_preemph #(
    parameter int          FRAME_LEN = 128,
    parameter int          HOP       = 64,
    parameter logic [31:0] COEF      = 32'd63570
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        in_ready,
    output logic [31:0] data_out,
    output logic        out_ready,
    output logic        out_last,
    output logic [15:0] frame_no,
    output logic        overflow
);

    localparam int          DEPTH   = 256;
    localparam int          AW      = 8;
    localparam logic [15:0] LEN_W   = 16'(FRAME_LEN);
    localparam logic [15:0] LAST_W  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] HOP_W   = 16'(HOP);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [15:0] NEXT_W  = 16'(FRAME_LEN + HOP);

    typedef enum logic [1:0] {FILL, PRIME, EMIT} state_t;

    state_t state, state_n;

    logic [31:0]       ring [DEPTH];
    logic [31:0]       x_prev, y_reg, y_next;
    logic              y_valid;
    logic [15:0]       wr_cnt, start, rd_cnt, fill_lvl, pend_lvl;
    logic              cont, emitted, accept, drop;
    logic [AW-1:0]     rd_addr;
    logic signed [63:0] coef_ext, x_ext, prod;

    assign coef_ext = {{32{COEF[31]}}, COEF};
    assign x_ext    = {{32{x_prev[31]}}, x_prev};
    assign prod     = coef_ext * x_ext;
    assign y_next   = data_in - 32'(prod >>> 16);

    // Counters are free-running mod 2^16; only their differences matter.
    assign fill_lvl = wr_cnt - start;
    assign pend_lvl = fill_lvl + {15'd0, y_valid};
    assign accept   = ~in_ready;
    assign drop     = accept && (pend_lvl >= DEPTH_W);
    assign rd_addr  = (state == EMIT && rd_cnt == LEN_W) ? AW'(start + HOP_W)
                                                         : AW'(start + rd_cnt);

    always_comb begin
        // NOTE: default first so every path assigns state_n and no latch is inferred.
        state_n = state;
        case (state)
            FILL:    if (fill_lvl >= LEN_W) state_n = PRIME;
            PRIME:   state_n = EMIT;
            EMIT:    if (rd_cnt == LEN_W && !cont) state_n = FILL;
            default: state_n = FILL;
        endcase
    end

    // NOTE: the ring holds data only; it is never reset, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (y_valid) ring[wr_cnt[AW-1:0]] <= y_reg;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout so all state updates see pre-edge values.
        if (rst) begin
            state     <= FILL;
            x_prev    <= '0;
            y_reg     <= '0;
            y_valid   <= 1'b0;
            wr_cnt    <= '0;
            start     <= '0;
            rd_cnt    <= '0;
            cont      <= 1'b0;
            emitted   <= 1'b0;
            data_out  <= '0;
            out_ready <= 1'b1;
            out_last  <= 1'b0;
            frame_no  <= '0;
            overflow  <= 1'b0;
        end else begin
            state   <= state_n;
            y_valid <= accept && !drop;
            if (accept && !drop) begin
                y_reg  <= y_next;
                x_prev <= data_in;
            end
            if (drop)    overflow <= 1'b1;
            if (y_valid) wr_cnt   <= wr_cnt + 16'd1;

            case (state)
                PRIME: begin
                    data_out  <= ring[rd_addr];
                    out_ready <= 1'b0;
                    out_last  <= 1'b0;
                    rd_cnt    <= 16'd1;
                    emitted   <= 1'b1;
                    if (emitted) frame_no <= frame_no + 16'd1;
                end
                EMIT: begin
                    if (rd_cnt == LEN_W) begin
                        // Last word is on the bus; either chain the next frame or go idle.
                        start    <= start + HOP_W;
                        out_last <= 1'b0;
                        if (cont) begin
                            data_out <= ring[rd_addr];
                            rd_cnt   <= 16'd1;
                            frame_no <= frame_no + 16'd1;
                        end else begin
                            out_ready <= 1'b1;
                            rd_cnt    <= '0;
                        end
                    end else begin
                        data_out <= ring[rd_addr];
                        out_last <= (rd_cnt == LAST_W);
                        rd_cnt   <= rd_cnt + 16'd1;
                        if (rd_cnt == LAST_W) cont <= (fill_lvl >= NEXT_W);
                    end
                end
                default: begin
                    out_ready <= 1'b1;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_preemph.sv
// Directed bench for frame_preemph: table of short two-sample patterns plus
// ramp, overflow, mid-frame reset and long-idle sequences.
module tb_frame_preemph;

    localparam logic [31:0] COEF = 32'd63570;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_ready = 1'b1;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        out_ready, out_last, overflow;
    logic [15:0] frame_no;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic [15:0] fno;
        int          cyc;
    } word_t;
    word_t cap_q[$];

    typedef struct {
        logic [31:0] x0, x1, xr;
        logic [31:0] w0, w1, w2, wr;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] xm[512];
    logic [31:0] ym[512];

    frame_preemph #(.FRAME_LEN(128), .HOP(64), .COEF(COEF)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_ready(in_ready),
        .data_out(data_out), .out_ready(out_ready), .out_last(out_last),
        .frame_no(frame_no), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (out_ready === 1'b0)
            cap_q.push_back('{d: data_out, last: out_last, fno: frame_no, cyc: cyc});

    initial begin
        #400000;
        $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pe(input logic [31:0] x, input logic [31:0] xp);
        longint p;
        p = longint'(signed'(xp)) * longint'(signed'(COEF));
        return x - 32'(p >>> 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A junk sample is presented on the reset edge and must be ignored.
    task automatic do_reset();
        rst = 1'b1; in_ready = 1'b0; data_in = 32'h1234_5678;
        tick();
        rst = 1'b0; in_ready = 1'b1; data_in = '0;
        cap_q.delete();
    endtask

    task automatic feed(input logic [31:0] x);
        in_ready = 1'b0; data_in = x;
        tick();
        in_ready = 1'b1;
        acc_cyc = cyc;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, " words arrived"}, 32'(cap_q.size() >= n), 32'd1);
    endtask

    task automatic build_ramp();
        for (int i = 0; i < 512; i++) begin
            xm[i] = 32'(i) << 16;
            ym[i] = pe(xm[i], (i == 0) ? 32'd0 : xm[i-1]);
        end
    endtask

    task automatic check_model(input int base, input int first_y, input string tag);
        for (int i = 0; i < 128; i++)
            check($sformatf("%s w%0d", tag, i), cap_q[base+i].d, ym[first_y+i]);
    endtask

    task automatic check_shape(input int base, input logic [15:0] fno, input string tag);
        check({tag, " frame_no"}, 32'(cap_q[base].fno), 32'(fno));
        for (int i = 0; i < 128; i++) begin
            check($sformatf("%s last%0d", tag, i), 32'(cap_q[base+i].last), 32'(i == 127));
            if (i > 0)
                check($sformatf("%s gap%0d", tag, i), cap_q[base+i].cyc, cap_q[base+i-1].cyc + 1);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                    32'h0001_0000, 32'h0000_07AE, 32'h0000_07AE, 32'h0000_07AE};
        vecs[1] = '{32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000,
                    32'hFFFF_0000, 32'h0000_F852, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{32'h0002_0000, 32'h0000_8000, 32'h0000_0000,
                    32'h0002_0000, 32'hFFFE_8F5C, 32'hFFFF_83D7, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000,
                    32'hFFFF_FFFF, 32'h0000_0004, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[4] = '{32'h8000_0000, 32'h7FFF_0000, 32'h0000_0000,
                    32'h8000_0000, 32'hFC28_0000, 32'h83D7_F852, 32'h0000_0000};
        vecs[5] = '{32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                    32'h0001_0000, 32'hFFFE_07AE, 32'hFFFF_F852, 32'hFFFF_F852};

        do_reset();
        check("rst out_ready", 32'(out_ready), 32'd1);
        check("rst out_last",  32'(out_last),  32'd0);
        check("rst data_out",  data_out,       32'd0);
        check("rst frame_no",  32'(frame_no),  32'd0);
        check("rst overflow",  32'(overflow),  32'd0);

        // Table: x0, x1, then 126 copies of xr, one sample per cycle.
        for (int v = 0; v < 6; v++) begin
            string t;
            t = $sformatf("vec%0d", v);
            do_reset();
            feed(vecs[v].x0);
            feed(vecs[v].x1);
            for (int i = 0; i < 126; i++) feed(vecs[v].xr);
            wait_words(128, 400, t);
            check({t, " latency"}, cap_q[0].cyc, acc_cyc + 3);
            check({t, " w0"}, cap_q[0].d, vecs[v].w0);
            check({t, " w1"}, cap_q[1].d, vecs[v].w1);
            check({t, " w2"}, cap_q[2].d, vecs[v].w2);
            for (int i = 3; i < 128; i++)
                check($sformatf("%s w%0d", t, i), cap_q[i].d, vecs[v].wr);
            check_shape(0, 16'd0, t);
            check({t, " overflow"}, 32'(overflow), 32'd0);
        end

        // Ramp at one sample per two cycles: two overlapping frames, no overflow.
        build_ramp();
        do_reset();
        for (int i = 0; i < 192; i++) begin
            feed(xm[i]);
            tick();
        end
        wait_words(256, 800, "ramp");
        check_model(0, 0, "ramp f0");
        check_model(128, 64, "ramp f1");
        for (int i = 0; i < 64; i++)
            check($sformatf("ramp overlap%0d", i), cap_q[128+i].d, cap_q[64+i].d);
        check_shape(0, 16'd0, "ramp f0");
        check_shape(128, 16'd1, "ramp f1");
        check("ramp overflow", 32'(overflow), 32'd0);
        repeat (50) tick();
        check("ramp no extra frame", 32'(cap_q.size()), 32'd256);

        // 512 samples back to back: overflow must trip and stay set.
        do_reset();
        for (int i = 0; i < 512; i++) feed(xm[i]);
        begin
            int k = 0, stable = 0, last_sz = -1;
            while (stable < 200 && k < 6000) begin
                tick();
                k++;
                if (cap_q.size() == last_sz) stable++;
                else begin
                    stable = 0;
                    last_sz = cap_q.size();
                end
            end
            check("burst idle reached", 32'(stable >= 200), 32'd1);
        end
        check("burst overflow", 32'(overflow), 32'd1);
        check("burst whole frames", 32'(cap_q.size() % 128), 32'd0);
        check("burst min frames", 32'(cap_q.size() >= 384), 32'd1);
        check_model(0, 0, "burst f0");
        check_model(128, 64, "burst f1");
        check_model(256, 128, "burst f2");
        check("burst chained", cap_q[128].cyc, cap_q[127].cyc + 1);
        for (int f = 0; f < cap_q.size() / 128; f++)
            check_shape(f * 128, 16'(f), $sformatf("burst f%0d", f));
        for (int f = 0; f + 1 < cap_q.size() / 128; f++)
            for (int i = 0; i < 64; i++)
                check($sformatf("burst ov f%0d w%0d", f, i),
                      cap_q[(f+1)*128+i].d, cap_q[f*128+64+i].d);
        repeat (20) tick();
        check("burst overflow sticky", 32'(overflow), 32'd1);

        // Reset on word 50 of frame 0 aborts the frame and clears x[n-1].
        do_reset();
        for (int i = 0; i < 128; i++) feed(32'h0001_0000);
        begin
            int k = 0;
            while (cap_q.size() < 50 && k < 400) begin
                tick();
                k++;
            end
        end
        check("abort at word50", data_out, 32'h0000_07AE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort out_ready", 32'(out_ready), 32'd1);
        check("abort out_last",  32'(out_last),  32'd0);
        check("abort data_out",  data_out,       32'd0);
        repeat (20) tick();
        check("abort no more words", 32'(cap_q.size()), 32'd51);
        cap_q.delete();
        for (int i = 0; i < 128; i++) feed(32'h0003_0000);
        wait_words(128, 400, "after abort");
        check("after abort w0", cap_q[0].d, 32'h0003_0000);
        check("after abort w1", cap_q[1].d, 32'h0000_170A);
        check("after abort frame_no", 32'(cap_q[0].fno), 32'd0);

        // 127 samples then a long idle: nothing moves until the 128th sample.
        do_reset();
        for (int i = 0; i < 127; i++) feed(xm[i]);
        begin
            int lows = 0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (out_ready !== 1'b1) lows++;
            end
            check("idle out_ready lows", 32'(lows), 32'd0);
        end
        check("idle words", 32'(cap_q.size()), 32'd0);
        check("idle frame_no", 32'(frame_no), 32'd0);
        check("idle overflow", 32'(overflow), 32'd0);
        feed(xm[127]);
        wait_words(128, 400, "idle");
        check("idle latency", cap_q[0].cyc, acc_cyc + 3);
        check_model(0, 0, "idle f0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
